// File: rtl/adc_emulator.sv
// Serial ADC emulator: a waveform generator feeds a 16-bit SPI-style frame shifter
// clocked by an external master; adc_cs/adc_clk are resynchronised into mclk.
module adc_emulator #(
  parameter int DATA_WIDTH = 12,
  parameter int LEAD_ZEROS = 4,
  parameter int HP_WIDTH   = 26
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  adc_cs,
  input  logic                  adc_clk,
  output logic                  adc_d0,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] level_lo,
  input  logic [DATA_WIDTH-1:0] level_hi,
  input  logic [HP_WIDTH-1:0]   half_period,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  frame_done,
  output logic                  frame_abort
);
  localparam int FRAME_W = LEAD_ZEROS + DATA_WIDTH;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] MODE_CONST  = 2'b00;
  localparam logic [1:0] MODE_SQUARE = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;
  localparam logic [1:0] MODE_RAMP   = 2'b11;

  // Returns {direction_up, next_value}; never steps outside [0, 2^DATA_WIDTH-1].
  function automatic logic [DATA_WIDTH:0] tri_next(input logic [DATA_WIDTH-1:0] cur,
                                                   input logic [DATA_WIDTH-1:0] lo,
                                                   input logic [DATA_WIDTH-1:0] hi,
                                                   input logic up);
    logic [DATA_WIDTH:0] r;
    if (up) r = (cur >= hi) ? {1'b0, cur - ONE} : {1'b1, cur + ONE};
    else    r = (cur <= lo) ? {1'b1, cur + ONE} : {1'b0, cur - ONE};
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] ramp_next(input logic [DATA_WIDTH-1:0] cur,
                                                      input logic [DATA_WIDTH-1:0] lo,
                                                      input logic [DATA_WIDTH-1:0] hi);
    return (cur >= hi) ? lo : cur + ONE;
  endfunction

  // Stage p0/p1: two-flop synchronisers; p2: delayed copy for edge detection
  logic cs_p0, cs_p1, cs_p2;
  logic clk_p0, clk_p1, clk_p2;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      cs_p0  <= 1'b1;
      cs_p1  <= 1'b1;
      cs_p2  <= 1'b1;
      clk_p0 <= 1'b0;
      clk_p1 <= 1'b0;
      clk_p2 <= 1'b0;
    end else begin
      cs_p0  <= adc_cs;
      cs_p1  <= cs_p0;
      cs_p2  <= cs_p1;
      clk_p0 <= adc_clk;
      clk_p1 <= clk_p0;
      clk_p2 <= clk_p1;
    end
  end

  logic cs_fall, cs_rise, clk_fall;
  assign cs_fall  = cs_p2 & ~cs_p1;
  assign cs_rise  = ~cs_p2 & cs_p1;
  assign clk_fall = clk_p2 & ~clk_p1 & ~cs_p1;

  // Serial frame FSM
  logic [1:0]         state;
  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   bit_cnt;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            shreg   <= FRAME_W'(sample);
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            frame_abort <= 1'b1;
            state       <= ST_IDLE;
          end else if (clk_fall) begin
            shreg   <= {shreg[FRAME_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              frame_done <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (cs_rise) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign adc_d0 = (state == ST_SHIFT) ? shreg[FRAME_W-1] : 1'b0;

  // Waveform generator
  logic [HP_WIDTH-1:0] tick_cnt, hp_last;
  logic [1:0]          mode_q;
  logic                restart_pend, tri_up, sq_hi;
  logic                tick, restart, levels_bad;
  logic [DATA_WIDTH:0] tri_res;

  assign hp_last    = (half_period == '0) ? '0 : half_period - HP_WIDTH'(1);
  assign tick       = (tick_cnt >= hp_last);
  assign restart    = restart_pend | (mode != mode_q);
  assign levels_bad = (level_lo >= level_hi);
  assign tri_res    = tri_next(sample, level_lo, level_hi, tri_up);

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      sample       <= '0;
      tick_cnt     <= '0;
      mode_q       <= MODE_CONST;
      restart_pend <= 1'b1;
      tri_up       <= 1'b1;
      sq_hi        <= 1'b0;
    end else begin
      restart_pend <= 1'b0;
      mode_q       <= mode;
      if (restart) begin
        tick_cnt <= '0;
        tri_up   <= 1'b1;
        sq_hi    <= 1'b0;
        sample   <= (mode == MODE_CONST || levels_bad) ? level_hi : level_lo;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + HP_WIDTH'(1);
        if (levels_bad) begin
          sample <= level_hi;
        end else if (tick) begin
          case (mode)
            MODE_CONST:  sample <= level_hi;
            MODE_SQUARE: begin
              sq_hi  <= ~sq_hi;
              sample <= sq_hi ? level_lo : level_hi;
            end
            MODE_TRI: begin
              tri_up <= tri_res[DATA_WIDTH];
              sample <= tri_res[DATA_WIDTH-1:0];
            end
            MODE_RAMP:   sample <= ramp_next(sample, level_lo, level_hi);
            default:     sample <= level_hi;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_emulator.sv
// Scoreboard bench for adc_emulator: stimulus queues expected frames and samples,
// one monitor process pops and compares as the DUT presents them.
module tb_adc_emulator;
  typedef struct packed {
    logic        abort;
    logic [4:0]  nbits;
    logic [15:0] bits;
  } frame_t;

  logic        mclk = 1'b0;
  logic        rst = 1'b1;
  logic        adc_cs = 1'b1;
  logic        adc_clk = 1'b0;
  logic        adc_d0;
  logic [1:0]  mode = 2'b00;
  logic [11:0] level_lo = 12'd0;
  logic [11:0] level_hi = 12'hA5C;
  logic [25:0] half_period = 26'd1;
  logic [11:0] sample;
  logic        frame_done, frame_abort;

  frame_t      frame_q[$];
  logic [11:0] gen_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        stim_done = 1'b0;
  logic [15:0] cap = '0;
  int          ncap = 0;
  frame_t      mon_f;
  logic [11:0] mon_s;
  int          tri_exp [7] = '{5, 6, 7, 6, 5, 6, 7};

  adc_emulator #(.DATA_WIDTH(12), .LEAD_ZEROS(4), .HP_WIDTH(26)) dut (
    .mclk(mclk), .rst(rst), .adc_cs(adc_cs), .adc_clk(adc_clk), .adc_d0(adc_d0),
    .mode(mode), .level_lo(level_lo), .level_hi(level_hi), .half_period(half_period),
    .sample(sample), .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 mclk = ~mclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic frame_t mk_frame(input logic ab, input logic [4:0] n, input logic [15:0] b);
    frame_t f;
    f.abort = ab;
    f.nbits = n;
    f.bits  = b;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Master-side capture: master samples adc_d0 on each adc_clk rise.
  always @(posedge adc_clk or negedge adc_cs) begin
    if (!adc_clk) begin
      cap  = '0;
      ncap = 0;
    end else if (!adc_cs) begin
      cap  = {cap[14:0], adc_d0};
      ncap = ncap + 1;
    end
  end

  always @(negedge mclk) begin
    if (rst) begin
      check("rst_adc_d0", 32'(adc_d0), 32'd0);
      check("rst_sample", 32'(sample), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_frame_abort", 32'(frame_abort), 32'd0);
    end else begin
      if (frame_done || frame_abort) begin
        if (frame_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_status: frame_done=%0b frame_abort=%0b none expected",
                   frame_done, frame_abort);
        end else begin
          mon_f = frame_q.pop_front();
          check("frame_abort", 32'(frame_abort), 32'(mon_f.abort));
          check("frame_done", 32'(frame_done), 32'(!mon_f.abort));
          check("frame_bits", 32'(cap), 32'(mon_f.bits));
          check("frame_nbits", 32'(ncap), 32'(mon_f.nbits));
          check("d0_after_frame", 32'(adc_d0), 32'd0);
        end
      end
      if (gen_q.size() != 0) begin
        mon_s = gen_q.pop_front();
        check("sample", 32'(sample), 32'(mon_s));
      end
    end
    if (stim_done) begin
      check("frame_queue_empty", 32'(frame_q.size()), 32'd0);
      check("gen_queue_empty", 32'(gen_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic wait_mclk(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  // adc_clk runs at mclk/8: 4 mclk high, 4 mclk low per bit.
  task automatic run_frame(input int nfalls, input int hi_change_at);
    adc_cs = 1'b0;
    wait_mclk(4);
    for (int i = 0; i < nfalls; i++) begin
      adc_clk = 1'b1;
      wait_mclk(4);
      adc_clk = 1'b0;
      if (i == hi_change_at) level_hi = 12'h123;
      wait_mclk(4);
    end
  endtask

  task automatic end_frame();
    adc_cs = 1'b1;
    wait_mclk(8);
  endtask

  task automatic wait_gen_empty();
    for (int i = 0; i < 200 && gen_q.size() != 0; i++) wait_mclk(1);
  endtask

  initial begin
    wait_mclk(3);
    rst = 1'b0;
    wait_mclk(4);

    frame_q.push_back(mk_frame(1'b0, 5'd16, 16'h0A5C));
    run_frame(16, -1);
    end_frame();

    frame_q.push_back(mk_frame(1'b1, 5'd7, 16'h0005));
    run_frame(7, -1);
    end_frame();

    frame_q.push_back(mk_frame(1'b0, 5'd16, 16'h0A5C));
    run_frame(16, 3);
    end_frame();
    level_hi = 12'hA5C;
    wait_mclk(2);

    run_frame(9, -1);
    rst = 1'b1;
    wait_mclk(1);
    adc_cs  = 1'b1;
    adc_clk = 1'b0;
    wait_mclk(2);
    rst = 1'b0;
    wait_mclk(4);

    frame_q.push_back(mk_frame(1'b0, 5'd16, 16'h0A5C));
    run_frame(16, -1);
    end_frame();

    mode = 2'b01; level_lo = 12'd100; level_hi = 12'd3000; half_period = 26'd10;
    @(posedge mclk);
    for (int r = 0; r < 2; r++) begin
      repeat (10) gen_q.push_back(12'd100);
      repeat (10) gen_q.push_back(12'd3000);
    end
    wait_gen_empty();

    mode = 2'b10; level_lo = 12'd5; level_hi = 12'd7; half_period = 26'd1;
    @(posedge mclk);
    for (int i = 0; i < 7; i++) gen_q.push_back(12'(tri_exp[i]));
    wait_gen_empty();

    mode = 2'b11; level_lo = 12'd4094; level_hi = 12'd4095; half_period = 26'd0;
    @(posedge mclk);
    for (int i = 0; i < 5; i++) gen_q.push_back((i % 2 == 0) ? 12'd4094 : 12'd4095);
    wait_gen_empty();

    level_lo = 12'd50; level_hi = 12'd20;
    @(posedge mclk);
    repeat (5) gen_q.push_back(12'd20);
    wait_gen_empty();

    wait_mclk(20);
    stim_done = 1'b1;
  end
endmodule
